// File: rtl/rx_bit_timer.sv
// Bit timer for the UART receive path: per-bit sample strobes and end-of-packet
// pulse for 5-9 data bits, optional parity and 1 or 2 stop bits, programmable period.
module rx_bit_timer #(
  parameter int unsigned CNT_WIDTH  = 14,
  parameter bit          MID_SAMPLE = 1'b0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable_timer,
  input  logic [CNT_WIDTH-1:0] bit_period,
  input  logic [3:0]           data_bits,
  input  logic                 parity_en,
  input  logic                 two_stop,
  output logic                 shift_strobe,
  output logic                 parity_strobe,
  output logic                 stop_strobe,
  output logic                 packet_done,
  output logic [3:0]           bit_index,
  output logic                 timer_busy,
  output logic                 config_error
);

  // One extra counter bit so P + floor(P/2) never wraps.
  localparam int unsigned CW = CNT_WIDTH + 1;
  localparam int unsigned IW = 4;
  localparam logic [CNT_WIDTH-1:0] P_MIN = CNT_WIDTH'(2);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [CNT_WIDTH-1:0] period_q, period_nxt;
  logic [IW-1:0]        dbits_q, dbits_nxt;
  logic [IW-1:0]        total_q, total_nxt;
  logic                 par_q, par_nxt;
  logic                 first_q, first_nxt;

  logic                 shift_nxt, par_s_nxt, stop_nxt, done_nxt, busy_nxt, cerr_nxt;
  logic [IW-1:0]        idx_nxt;
  logic [CW-1:0]        half_period, first_target, target;

  // The first strobe lands after F = P (+ floor(P/2) when sampling mid-bit).
  assign half_period  = MID_SAMPLE ? CW'(period_q >> 1) : '0;
  assign first_target = CW'(period_q) + half_period;
  assign target       = first_q ? first_target : CW'(period_q);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      cnt           <= '0;
      period_q      <= '0;
      dbits_q       <= '0;
      total_q       <= '0;
      par_q         <= 1'b0;
      first_q       <= 1'b0;
      shift_strobe  <= 1'b0;
      parity_strobe <= 1'b0;
      stop_strobe   <= 1'b0;
      packet_done   <= 1'b0;
      bit_index     <= '0;
      timer_busy    <= 1'b0;
      config_error  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      period_q      <= period_nxt;
      dbits_q       <= dbits_nxt;
      total_q       <= total_nxt;
      par_q         <= par_nxt;
      first_q       <= first_nxt;
      shift_strobe  <= shift_nxt;
      parity_strobe <= par_s_nxt;
      stop_strobe   <= stop_nxt;
      packet_done   <= done_nxt;
      bit_index     <= idx_nxt;
      timer_busy    <= busy_nxt;
      config_error  <= cerr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    period_nxt = period_q;
    dbits_nxt  = dbits_q;
    total_nxt  = total_q;
    par_nxt    = par_q;
    first_nxt  = first_q;
    shift_nxt  = 1'b0;
    par_s_nxt  = 1'b0;
    stop_nxt   = 1'b0;
    done_nxt   = 1'b0;
    busy_nxt   = 1'b0;
    idx_nxt    = bit_index;
    cerr_nxt   = config_error;

    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
        if (enable_timer) begin
          period_nxt = bit_period;
          dbits_nxt  = data_bits;
          par_nxt    = parity_en;
          total_nxt  = IW'(data_bits + {3'b000, parity_en} + 4'd1 + {3'b000, two_stop});
          if ((bit_period < P_MIN) || (data_bits < 4'd5) || (data_bits > 4'd9)) begin
            state_nxt = ERR;
            cerr_nxt  = 1'b1;
          end else begin
            state_nxt = RUN;
            cnt_nxt   = CW'(1);
            first_nxt = 1'b1;
            busy_nxt  = 1'b1;
            cerr_nxt  = 1'b0;
          end
        end
      end

      RUN: begin
        if (!enable_timer) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else if (packet_done) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
          idx_nxt   = bit_index + 4'd1;
        end else begin
          busy_nxt = 1'b1;
          if (shift_strobe) begin
            cnt_nxt = CW'(1);
            idx_nxt = bit_index + 4'd1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
          // Strobes are at least two cycles apart, so bit_index is current here.
          if (cnt_nxt == target) begin
            shift_nxt = 1'b1;
            first_nxt = 1'b0;
            par_s_nxt = par_q && (bit_index == dbits_q);
            stop_nxt  = (bit_index >= IW'(dbits_q + {3'b000, par_q}));
            done_nxt  = (bit_index == IW'(total_q - 4'd1));
          end
        end
      end

      DONE: begin
        if (!enable_timer) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end
      end

      ERR: begin
        if (!enable_timer) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Self-checking bench for rx_bit_timer: directed format cases plus randomized
// packets compared each cycle against an arithmetic model of the strobe timeline.
module tb_rx_bit_timer;

  localparam int unsigned CNT_WIDTH = 14;

  logic                 clk;
  logic                 n_rst;
  logic                 en0, en1;
  logic [CNT_WIDTH-1:0] bit_period;
  logic [3:0]           data_bits;
  logic                 parity_en;
  logic                 two_stop;

  logic       s0_shift, s0_par, s0_stop, s0_done, s0_busy, s0_cerr;
  logic [3:0] s0_idx;
  logic       s1_shift, s1_par, s1_stop, s1_done, s1_busy, s1_cerr;
  logic [3:0] s1_idx;

  int  compared;
  int  mismatched;
  bit  sel;

  logic [9:0] obs0, obs1, obs;

  rx_bit_timer #(.CNT_WIDTH(CNT_WIDTH), .MID_SAMPLE(1'b0)) dut (
    .clk(clk), .n_rst(n_rst), .enable_timer(en0), .bit_period(bit_period),
    .data_bits(data_bits), .parity_en(parity_en), .two_stop(two_stop),
    .shift_strobe(s0_shift), .parity_strobe(s0_par), .stop_strobe(s0_stop),
    .packet_done(s0_done), .bit_index(s0_idx), .timer_busy(s0_busy),
    .config_error(s0_cerr)
  );

  rx_bit_timer #(.CNT_WIDTH(CNT_WIDTH), .MID_SAMPLE(1'b1)) dut_mid (
    .clk(clk), .n_rst(n_rst), .enable_timer(en1), .bit_period(bit_period),
    .data_bits(data_bits), .parity_en(parity_en), .two_stop(two_stop),
    .shift_strobe(s1_shift), .parity_strobe(s1_par), .stop_strobe(s1_stop),
    .packet_done(s1_done), .bit_index(s1_idx), .timer_busy(s1_busy),
    .config_error(s1_cerr)
  );

  assign obs0 = {s0_shift, s0_par, s0_stop, s0_done, s0_busy, s0_cerr, s0_idx};
  assign obs1 = {s1_shift, s1_par, s1_stop, s1_done, s1_busy, s1_cerr, s1_idx};
  assign obs  = sel ? obs1 : obs0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge: the start of the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input bit mid, input logic v);
    if (mid) en1 = v;
    else     en0 = v;
  endtask

  // Expected {shift,parity,stop,done,busy,cerr,idx} at offset o after the
  // capture cycle. Strobe k (0-based) falls at offset F + k*P; enable dropped
  // during cycle 'drop' leaves everything idle from drop+1 onward.
  function automatic logic [9:0] model(input int o, input int f, input int p,
                                       input int d, input int par, input int n,
                                       input int drop);
    bit active;
    bit strb;
    bit busy;
    int k;
    int idx;
    active = (o <= drop);
    strb   = 1'b0;
    k      = 0;
    idx    = 0;
    if (active && o >= f && ((o - f) % p) == 0 && ((o - f) / p) < n) begin
      strb = 1'b1;
      k    = (o - f) / p;
    end
    if (active && o > f) idx = (((o - f - 1) / p + 1) < n) ? ((o - f - 1) / p + 1) : n;
    busy = active && (o >= 1) && (o <= f + (n - 1) * p);
    return {strb, strb && (par != 0) && (k == d), strb && (k >= d + par),
            strb && (k == n - 1), busy, 1'b0, 4'(idx)};
  endfunction

  // Start a packet in the current cycle and check every following cycle.
  task automatic run_packet(input bit mid, input int p, input int d, input bit par,
                            input bit two, input int abort_o, input int chg_o,
                            input int hold, input string name);
    int f, n, last, drop, endo;
    logic [9:0] exp;
    sel  = mid;
    f    = p + (mid ? p / 2 : 0);
    n    = d + int'(par) + 1 + int'(two);
    last = f + (n - 1) * p;
    drop = (abort_o >= 0) ? abort_o : last + hold;
    endo = drop + 3;
    bit_period = CNT_WIDTH'(p);
    data_bits  = 4'(d);
    parity_en  = par;
    two_stop   = two;
    set_en(mid, 1'b1);
    for (int o = 1; o <= endo; o++) begin
      step();
      exp = model(o, f, p, d, int'(par), n, drop);
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL %s offset %0d: observed %b expected %b", name, o, obs, exp);
      end
      if (o == drop) set_en(mid, 1'b0);
      if (o == chg_o) data_bits = 4'd5;
      // Unlatched inputs wander after capture; the packet must not notice.
      if (o == 1 && chg_o < 0) begin
        bit_period = CNT_WIDTH'($urandom_range(0, 3));
        parity_en  = ~par;
        two_stop   = ~two;
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    en0 = 1'b0; en1 = 1'b0;
    bit_period = '0; data_bits = '0; parity_en = 1'b0; two_stop = 1'b0;
    sel = 1'b0;
    #2;
    compared++;
    if (obs0 !== 10'b0) begin
      mismatched++;
      $display("FAIL reset_dut observed %b expected %b", obs0, 10'b0);
    end
    compared++;
    if (obs1 !== 10'b0) begin
      mismatched++;
      $display("FAIL reset_dut_mid observed %b expected %b", obs1, 10'b0);
    end
    #10 n_rst = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_default();
    run_packet(1'b0, 10, 8, 1'b0, 1'b0, -1, -1, 20, "default_format");
  endtask

  task automatic test_max_format();
    run_packet(1'b0, 4, 9, 1'b1, 1'b1, -1, -1, 4, "max_format");
  endtask

  task automatic test_mid_sample();
    run_packet(1'b1, 16, 5, 1'b0, 1'b0, -1, -1, 4, "mid_sample");
  endtask

  task automatic test_abort();
    run_packet(1'b0, 10, 8, 1'b0, 1'b0, 45, -1, 0, "abort");
    repeat (2) step();
    run_packet(1'b0, 10, 8, 1'b0, 1'b0, -1, -1, 2, "after_abort");
  endtask

  task automatic test_illegal();
    int ps[2];
    int ds[2];
    ps[0] = 10; ds[0] = 4;
    ps[1] = 1;  ds[1] = 8;
    sel = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bit_period = CNT_WIDTH'(ps[c]);
      data_bits  = 4'(ds[c]);
      en0 = 1'b1;
      for (int o = 1; o <= 6; o++) begin
        step();
        compared++;
        if (obs0 !== 10'b00000_1_0000) begin
          mismatched++;
          $display("FAIL illegal_cfg%0d offset %0d: observed %b expected %b",
                   c, o, obs0, 10'b00000_1_0000);
        end
      end
      en0 = 1'b0;
      step();
      step();
      compared++;
      if (obs0 !== 10'b00000_1_0000) begin
        mismatched++;
        $display("FAIL illegal_sticky%0d observed %b expected %b", c, obs0, 10'b00000_1_0000);
      end
    end
    run_packet(1'b0, 3, 6, 1'b1, 1'b0, -1, -1, 2, "legal_clears_error");
  endtask

  task automatic test_midpacket_change_and_reset();
    run_packet(1'b0, 10, 8, 1'b0, 1'b0, -1, 25, 3, "data_bits_change");
    sel = 1'b0;
    bit_period = CNT_WIDTH'(10);
    data_bits  = 4'd8;
    en0 = 1'b1;
    repeat (35) step();
    n_rst = 1'b0;
    en0 = 1'b0;
    #1;
    compared++;
    if (obs0 !== 10'b0) begin
      mismatched++;
      $display("FAIL async_reset observed %b expected %b", obs0, 10'b0);
    end
    #3 n_rst = 1'b1;
    for (int o = 1; o <= 70; o++) begin
      step();
      compared++;
      if (obs0 !== 10'b0) begin
        mismatched++;
        $display("FAIL post_reset_idle cycle %0d: observed %b expected %b", o, obs0, 10'b0);
      end
    end
  endtask

  task automatic test_wide_period();
    int p;
    p = (1 << CNT_WIDTH) - 1;
    run_packet(1'b1, p, 5, 1'b0, 1'b0, p + p / 2 + 3, -1, 0, "wide_period");
  endtask

  task automatic test_random();
    bit mid, par, two;
    int p, d, ab, f, n, last;
    for (int i = 0; i < 24; i++) begin
      mid  = 1'($urandom_range(0, 1));
      par  = 1'($urandom_range(0, 1));
      two  = 1'($urandom_range(0, 1));
      p    = $urandom_range(2, 12);
      d    = $urandom_range(5, 9);
      f    = p + (mid ? p / 2 : 0);
      n    = d + int'(par) + 1 + int'(two);
      last = f + (n - 1) * p;
      ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, last + 2) : -1;
      run_packet(mid, p, d, par, two, ab, -1, $urandom_range(0, 5), "random");
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_default();
    test_max_format();
    test_mid_sample();
    test_abort();
    test_illegal();
    test_midpacket_change_and_reset();
    test_random();
    test_wide_period();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
